// File: rtl/seq_div16x8.sv
// Purpose : iterative restoring divider, unsigned DW-bit dividend by VW-bit divisor -> quotient + remainder.
// Latency : result valid 17 cycles after accept (DW+1), 1 cycle for divide-by-zero; one op every DW+2 cycles.
// Backpress: single op in flight; in_ready low from accept until the result is taken; result held until out_ready.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        operation handshake, carries dividend[DW] and divisor[VW]
//   out_valid/out_ready      result handshake, carries quotient[DW], remainder[VW], div_by_zero
module seq_div16x8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] dvd;     // dividend bits shift out the top, quotient bits shift in at the bottom
    logic [VW-1:0] dsr;     // latched divisor
    logic [VW-1:0] pr;      // partial remainder; always < divisor between iterations
    logic [CW-1:0] count;

    // One restoring step. The shifted partial remainder is VW+1 bits so the
    // compare cannot overflow; after a successful subtract the result is
    // < divisor, so the low VW bits of the difference are exact.
    logic [VW:0]   pr_shift;
    logic          take;
    logic [VW-1:0] pr_next;
    logic [DW-1:0] dvd_next;

    always_comb begin
        pr_shift = {pr, dvd[DW-1]};
        take     = (pr_shift >= {1'b0, dsr});
        pr_next  = take ? (pr_shift[VW-1:0] - dsr) : pr_shift[VW-1:0];
        dvd_next = {dvd[DW-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            pr          <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is always 1 here, so in_valid alone is the accept
                    if (in_valid) begin
                        dvd      <= dividend;
                        dsr      <= divisor;
                        pr       <= '0;
                        count    <= CW'(DW - 1);
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // skip iteration: saturated quotient, dividend low bits as remainder
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    pr    <= pr_next;
                    dvd   <= dvd_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        // outputs load only here so they stay stable outside DONE
                        state       <= DONE;
                        quotient    <= dvd_next;
                        remainder   <= pr_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16x8.sv
// Purpose : directed + random self-checking bench for seq_div16x8 with an expected-result queue.
// Latency : checks accept-to-valid timing (17 / 1 cycles) and the 18-cycle back-to-back period.
// Backpress: exercises held out_ready, in_valid while busy, and reset mid-operation.
module tb_seq_div16x8;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } res_t;

    res_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    seq_div16x8 #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        res_t m;
        if (b == '0) begin
            m.q  = '1;
            m.r  = a[VW-1:0];
            m.dz = 1'b1;
        end else begin
            m.q  = a / DW'(b);
            m.r  = VW'(a % DW'(b));
            m.dz = 1'b0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit push);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready before issue", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after accept; waits for the result and checks it.
    task automatic collect(input int exp_lat, input bit release_out);
        int   lat = 1;
        res_t e;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("scoreboard nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        end
        chk("in_ready while done", 32'(in_ready), 32'd0);
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk("out_valid after take", 32'(out_valid), 32'd0);
            chk("in_ready after take", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst quotient", 32'(quotient), 32'd0);
        chk("rst remainder", 32'(remainder), 32'd0);
        chk("rst dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic divides; out_ready held high early to show it only acts in DONE
        out_ready = 1'b1;
        issue(16'h03E8, 8'h07, 1'b1);
        collect(17, 1'b1);
        chk("idle keeps q 1000/7", 32'(quotient), 32'd142);
        chk("idle keeps r 1000/7", 32'(remainder), 32'd6);
        issue(16'hFFFF, 8'h01, 1'b1);
        collect(17, 1'b1);
        issue(16'hFFFF, 8'hFF, 1'b1);
        collect(17, 1'b1);
        issue(16'd5, 8'd0, 1'b1);
        collect(1, 1'b1);
        chk("idle keeps dz", 32'(div_by_zero), 32'd1);

        // held result with in_valid attempted while busy
        out_ready = 1'b0;
        issue(16'd200, 8'd9, 1'b1);
        collect(17, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 16'd7;
            divisor  = 8'd1;
            @(negedge clk);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold quotient", 32'(quotient), 32'd22);
            chk("hold remainder", 32'(remainder), 32'd2);
            chk("hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy input not captured", 32'(in_ready), 32'd1);
            chk("no stray result", 32'(out_valid), 32'd0);
        end

        // reset during RUN abandons the op
        issue(16'd60000, 8'd3, 1'b0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst quotient", 32'(quotient), 32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        chk("midrst dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst no result", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        issue(16'd6, 8'd4, 1'b1);
        collect(17, 1'b1);

        // random (a*b)/b sweep, back-to-back with out_ready held
        begin
            int prev = 0;
            for (int i = 0; i < 2000; i++) begin
                logic [7:0]    a;
                logic [7:0]    b;
                logic [DW-1:0] p;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(1, 255));
                p = DW'(a) * DW'(b);
                issue(p, b, 1'b1);
                if (i > 0) chk("throughput period", 32'(acc_cyc - prev), 32'd18);
                prev = acc_cyc;
                collect(17, 1'b1);
                chk("sweep q==a", 32'(quotient), 32'(a));
                chk("sweep r==0", 32'(remainder), 32'd0);
            end
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
